// File: rtl/objram_arbiter.sv
// objram_arbiter: one-command-per-clock access controller for the 2Kx8 object
// attribute RAM, shared between CPU byte accesses and a full-table scanner that
// streams all 128x16 attribute bytes over a valid/ready port.
// Build option: define OBJRAM_SKIP_EMPTY_EN to skip bytes 1..15 of any object
// whose byte 0 reads back as 0x00.
module objram_arbiter (
    input  logic        i_MCLK,
    input  logic        i_RST_n,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WR,
    input  logic [10:0] i_CPU_ADDR,
    input  logic [7:0]  i_CPU_DIN,
    output logic [7:0]  o_CPU_DOUT,
    output logic        o_CPU_ACK,
    input  logic        i_SCAN_START,
    output logic        o_SCAN_BUSY,
    output logic        o_OBJ_VALID,
    input  logic        i_OBJ_READY,
    output logic [7:0]  o_OBJ_DATA,
    output logic [6:0]  o_OBJ_IDX,
    output logic [3:0]  o_OBJ_BYTE,
    output logic [10:0] o_RAM_ADDR,
    output logic [7:0]  o_RAM_DIN,
    output logic        o_RAM_WR_n,
    output logic        o_RAM_RD_n,
    input  logic [7:0]  i_RAM_DOUT
);

    typedef enum logic {S_IDLE, S_SCAN} scan_state_e;

    scan_state_e state_q;
    logic [10:0] ptr_q, tag_q, otag_q, sk_tag_q, ram_addr_q;
    logic [7:0]  dout_q, odata_q, sk_data_q, ram_din_q;
    logic        done_q, scan_slot_q, scan_land_q;
    logic        cpu_wr_slot_q, cpu_rd_slot_q, cpu_rd_land_q, cpu_out_q, ack_q;
    logic        ov_q, sk_v_q, prio_cpu_q, wr_n_q, rd_n_q;

    logic        pop, land_empty, last_pop;
    logic        cpu_elig, scan_elig, grant_cpu, grant_scan;
    logic [10:0] ptr_eff, ptr_d;
    logic        done_eff, done_d, cpu_out_d;

    // Eligibility, slot arbitration and scan pointer next-state.
    // A scan read may issue in the cycle its predecessor returns; a skid entry
    // absorbs that returning byte if the output register is then stalled.
    always_comb begin
        pop = ov_q & i_OBJ_READY;
`ifdef OBJRAM_SKIP_EMPTY_EN
        land_empty = scan_land_q & (tag_q[3:0] == 4'h0) & (i_RAM_DOUT == 8'h00);
        last_pop   = pop & (otag_q[10:4] == 7'h7F) &
                     ((otag_q[3:0] == 4'hF) | ((otag_q[3:0] == 4'h0) & (odata_q == 8'h00)));
`else
        land_empty = 1'b0;
        last_pop   = pop & (otag_q == 11'h7FF);
`endif
        ptr_eff    = land_empty ? {tag_q[10:4] + 7'd1, 4'h0} : ptr_q;
        done_eff   = done_q | (land_empty & (tag_q[10:4] == 7'h7F));
        cpu_elig   = i_CPU_REQ & ~cpu_out_q;
        scan_elig  = (state_q == S_SCAN) & ~done_eff & ~scan_slot_q & ~sk_v_q &
                     (~ov_q | i_OBJ_READY);
        grant_cpu  = cpu_elig & (~scan_elig | prio_cpu_q);
        grant_scan = scan_elig & ~grant_cpu;
        ptr_d      = grant_scan ? ptr_eff + 11'd1 : ptr_eff;
        done_d     = done_eff | (grant_scan & (ptr_eff == 11'h7FF));
        cpu_out_d  = grant_cpu | (cpu_out_q & ~ack_q);
    end

    // Registered RAM command slot, CPU handshake pipeline, scanner FSM and output buffer.
    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            tag_q         <= '0;
            otag_q        <= '0;
            sk_tag_q      <= '0;
            ram_addr_q    <= '0;
            dout_q        <= '0;
            odata_q       <= '0;
            sk_data_q     <= '0;
            ram_din_q     <= '0;
            done_q        <= 1'b0;
            scan_slot_q   <= 1'b0;
            scan_land_q   <= 1'b0;
            cpu_wr_slot_q <= 1'b0;
            cpu_rd_slot_q <= 1'b0;
            cpu_rd_land_q <= 1'b0;
            cpu_out_q     <= 1'b0;
            ack_q         <= 1'b0;
            ov_q          <= 1'b0;
            sk_v_q        <= 1'b0;
            prio_cpu_q    <= 1'b1;
            wr_n_q        <= 1'b1;
            rd_n_q        <= 1'b1;
        end else begin
            wr_n_q <= ~(grant_cpu & i_CPU_WR);
            rd_n_q <= ~(grant_scan | (grant_cpu & ~i_CPU_WR));
            if (grant_cpu) begin
                ram_addr_q <= i_CPU_ADDR;
            end else if (grant_scan) begin
                ram_addr_q <= ptr_eff;
            end
            if (grant_cpu & i_CPU_WR) begin
                ram_din_q <= i_CPU_DIN;
            end

            cpu_wr_slot_q <= grant_cpu & i_CPU_WR;
            cpu_rd_slot_q <= grant_cpu & ~i_CPU_WR;
            cpu_rd_land_q <= cpu_rd_slot_q;
            scan_slot_q   <= grant_scan;
            scan_land_q   <= scan_slot_q;
            cpu_out_q     <= cpu_out_d;
            ack_q         <= cpu_wr_slot_q | cpu_rd_land_q;
            if (cpu_rd_land_q) begin
                dout_q <= i_RAM_DOUT;
            end
            if (cpu_elig & scan_elig) begin
                prio_cpu_q <= ~grant_cpu;
            end
            if (grant_scan) begin
                tag_q <= ptr_eff;
            end

            if (sk_v_q) begin
                if (pop) begin
                    odata_q <= sk_data_q;
                    otag_q  <= sk_tag_q;
                    sk_v_q  <= 1'b0;
                end
            end else if (scan_land_q) begin
                if (~ov_q | pop) begin
                    ov_q    <= 1'b1;
                    odata_q <= i_RAM_DOUT;
                    otag_q  <= tag_q;
                end else begin
                    sk_v_q    <= 1'b1;
                    sk_data_q <= i_RAM_DOUT;
                    sk_tag_q  <= tag_q;
                end
            end else if (pop) begin
                ov_q <= 1'b0;
            end

            if (state_q == S_IDLE) begin
                if (i_SCAN_START) begin
                    state_q <= S_SCAN;
                    ptr_q   <= '0;
                    done_q  <= 1'b0;
                end
            end else begin
                ptr_q  <= ptr_d;
                done_q <= done_d;
                if (last_pop) begin
                    state_q <= S_IDLE;
                end
            end
        end
    end

    assign o_CPU_DOUT  = dout_q;
    assign o_CPU_ACK   = ack_q;
    assign o_SCAN_BUSY = (state_q == S_SCAN);
    assign o_OBJ_VALID = ov_q;
    assign o_OBJ_DATA  = odata_q;
    assign o_OBJ_IDX   = otag_q[10:4];
    assign o_OBJ_BYTE  = otag_q[3:0];
    assign o_RAM_ADDR  = ram_addr_q;
    assign o_RAM_DIN   = ram_din_q;
    assign o_RAM_WR_n  = wr_n_q;
    assign o_RAM_RD_n  = rd_n_q;

endmodule

// File: tb/tb_objram_arbiter.sv
// Testbench for objram_arbiter: CPU access vector table, scan scoreboard against
// an address-order model of the table, stall/reset/contention sequences and a
// randomised CPU + READY phase.
module tb_objram_arbiter;

`ifdef OBJRAM_SKIP_EMPTY_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [10:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic        scan_start = 1'b0, scan_busy, obj_valid, obj_ready = 1'b0;
    logic [7:0]  obj_data;
    logic [6:0]  obj_idx;
    logic [3:0]  obj_byte;
    logic [10:0] ram_addr;
    logic [7:0]  ram_din, ram_dout = '0;
    logic        ram_wr_n, ram_rd_n;

    int n_cmp = 0, n_err = 0, cyc = 0;
    logic [7:0] mem   [2048];
    logic [7:0] mem_m [2048];

    // scan scoreboard state
    bit mon_en = 1'b0, last_pending = 1'b0;
    int exp_addr = 0, n_pops = 0, first_pop_cyc = -1, last_pop_cyc = 0;

    objram_arbiter dut (
        .i_MCLK(clk), .i_RST_n(rst_n),
        .i_CPU_REQ(cpu_req), .i_CPU_WR(cpu_wr), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
        .o_CPU_DOUT(cpu_dout), .o_CPU_ACK(cpu_ack),
        .i_SCAN_START(scan_start), .o_SCAN_BUSY(scan_busy),
        .o_OBJ_VALID(obj_valid), .i_OBJ_READY(obj_ready), .o_OBJ_DATA(obj_data),
        .o_OBJ_IDX(obj_idx), .o_OBJ_BYTE(obj_byte),
        .o_RAM_ADDR(ram_addr), .o_RAM_DIN(ram_din), .o_RAM_WR_n(ram_wr_n),
        .o_RAM_RD_n(ram_rd_n), .i_RAM_DOUT(ram_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // synchronous RAM with registered read data
    always @(posedge clk) begin
        if (!ram_wr_n) mem[ram_addr] <= ram_din;
        if (!ram_rd_n) ram_dout <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scan order: address order, optionally jumping past an empty object.
    function automatic int next_addr(input int a, input logic [7:0] d);
        if (SKIP && (a % 16) == 0 && d == 8'h00) return a + 16;
        return a + 1;
    endfunction

    function automatic int model_count();
        int a = 0, c = 0;
        while (a < 2048) begin
            c++;
            a = next_addr(a, mem_m[a]);
        end
        return c;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (last_pending) begin
                chk("busy_fall_after_last_pop", scan_busy, 0);
                last_pending = 1'b0;
            end
            if (obj_valid && obj_ready) begin
                if (exp_addr >= 2048) begin
                    chk("extra_pop", 1, 0);
                end else begin
                    chk("pop_data", obj_data, mem_m[exp_addr]);
                    chk("pop_idx", obj_idx, (exp_addr >> 4) & 127);
                    chk("pop_byte", obj_byte, exp_addr & 15);
                    chk("busy_during_pop", scan_busy, 1);
                    exp_addr = next_addr(exp_addr, mem_m[exp_addr]);
                    n_pops++;
                    if (first_pop_cyc < 0) first_pop_cyc = cyc;
                    last_pop_cyc = cyc;
                    if (exp_addr >= 2048) last_pending = 1'b1;
                end
            end
        end
    end

    task automatic mon_reset();
        exp_addr = 0; n_pops = 0; first_pop_cyc = -1; last_pending = 1'b0; mon_en = 1'b1;
    endtask

    task automatic preload();
        for (int i = 0; i < 2048; i++) begin
            logic [10:0] a;
            a = i[10:0];
            mem[i] = a[7:0];
            if (SKIP && a[3:0] == 4'h0)
                mem[i] = (a[10:4] == 7'd0 || a[10:4] == 7'd2) ? 8'h00 : 8'hA5;
            mem_m[i] = mem[i];
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_dout", cpu_dout, 0);   chk("rst_ack", cpu_ack, 0);
        chk("rst_busy", scan_busy, 0);  chk("rst_valid", obj_valid, 0);
        chk("rst_data", obj_data, 0);   chk("rst_idx", obj_idx, 0);
        chk("rst_byte", obj_byte, 0);   chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0); chk("rst_wr_n", ram_wr_n, 1);
        chk("rst_rd_n", ram_rd_n, 1);
    endtask

    task automatic cpu_op(input bit wr, input logic [10:0] a, input logic [7:0] d,
                          output int lat, output int wr_lo, output int rd_lo);
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = a; cpu_din = d;
        lat = 0; wr_lo = 0; rd_lo = 0;
        while (1) begin
            @(negedge clk); lat++;
            if (!ram_wr_n) wr_lo++;
            if (!ram_rd_n) rd_lo++;
            if (cpu_ack) break;
            if (lat >= 30) begin chk("cpu_ack_timeout", 0, 1); break; end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic start_scan();
        @(posedge clk); #1 scan_start = 1'b1;
        @(posedge clk); #1 scan_start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", scan_busy, 1);
    endtask

    task automatic wait_scan_done(input int budget);
        int k = 0;
        while (k < budget) begin
            @(negedge clk);
            if (!scan_busy) break;
            k++;
        end
        if (k >= budget) chk("scan_done_timeout", 0, 1);
        @(negedge clk);
    endtask

    typedef struct {
        bit          wr;
        logic [10:0] addr;
        logic [7:0]  din;
        logic [7:0]  exp_dout;
        int          exp_lat;
    } cpu_vec_t;

    initial begin
        cpu_vec_t vecs[6];
        int lat, wlo, rlo, c0, p0;
        logic [7:0] prev, held_d;
        logic [6:0] held_i;
        logic [3:0] held_b;
        bit ops_done;

        // REQ raised mid-cycle g: strobe in g+1, write ACK in g+2, read ACK in g+3.
        vecs[0] = '{1'b1, 11'h123, 8'h5A, 8'h00, 3};
        vecs[1] = '{1'b0, 11'h123, 8'h00, 8'h5A, 4};
        vecs[2] = '{1'b1, 11'h7FF, 8'hC3, 8'h00, 3};
        vecs[3] = '{1'b1, 11'h000, 8'h3C, 8'h00, 3};
        vecs[4] = '{1'b0, 11'h7FF, 8'h00, 8'hC3, 4};
        vecs[5] = '{1'b0, 11'h000, 8'h00, 8'h3C, 4};

        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        @(negedge clk) rst_n = 1'b1;

        // CPU access table, no scan running
        foreach (vecs[i]) begin
            prev = cpu_dout;
            cpu_op(vecs[i].wr, vecs[i].addr, vecs[i].din, lat, wlo, rlo);
            chk("cpu_ack_latency", lat, vecs[i].exp_lat);
            chk("cpu_wr_n_cycles", wlo, vecs[i].wr ? 1 : 0);
            chk("cpu_rd_n_cycles", rlo, vecs[i].wr ? 0 : 1);
            chk("cpu_dout", cpu_dout, vecs[i].wr ? {24'h0, prev} : {24'h0, vecs[i].exp_dout});
            if (vecs[i].wr) chk("cpu_addr_out", ram_addr, vecs[i].addr);
            if (vecs[i].wr) chk("cpu_din_out", ram_din, vecs[i].din);
        end

        // full scan, READY held high, with a START mid-scan that must be ignored
        preload();
        mon_reset();
        obj_ready = 1'b1;
        start_scan();
        repeat (300) @(posedge clk);
        #1 scan_start = 1'b1;
        @(posedge clk); #1 scan_start = 1'b0;
        wait_scan_done(6000);
        chk("full_pop_count", n_pops, model_count());
        chk("full_end_addr", exp_addr, 2048);
        chk("full_throughput", last_pop_cyc - first_pop_cyc, 2 * (n_pops - 1));

        // reset mid-scan with VALID high, then restart from {0,0}
        mon_reset();
        start_scan();
        repeat (40) @(posedge clk);
        #1 obj_ready = 1'b0;
        for (int k = 0; k < 10 && !obj_valid; k++) @(negedge clk);
        chk("valid_before_reset", obj_valid, 1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(negedge clk) rst_n = 1'b1;
        mon_reset();
        obj_ready = 1'b1;
        start_scan();
        repeat (200) @(posedge clk);

        // READY low for 10 cycles: outputs frozen, no new scan reads
        #1 obj_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 10 && !obj_valid; k++) @(negedge clk);
        chk("stall_valid", obj_valid, 1);
        held_d = obj_data; held_i = obj_idx; held_b = obj_byte;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_valid_hold", obj_valid, 1);
            chk("stall_data_hold", obj_data, held_d);
            chk("stall_idx_hold", obj_idx, held_i);
            chk("stall_byte_hold", obj_byte, held_b);
            if (k >= 1) chk("stall_rd_n_high", ram_rd_n, 1);
        end
        @(posedge clk); #1 obj_ready = 1'b1;
        wait_scan_done(6000);
        chk("stall_pop_count", n_pops, model_count());

        // START and contested CPU request in the first scan cycle: CPU wins
        preload();
        mon_reset();
        @(posedge clk); #1 scan_start = 1'b1;
        @(posedge clk); #1 scan_start = 1'b0;
        cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'h400; cpu_din = mem_m[11'h400];
        @(negedge clk);
        chk("contest_idle_wr_n", ram_wr_n, 1);
        chk("contest_idle_rd_n", ram_rd_n, 1);
        @(negedge clk);
        chk("contest_cpu_first_wr_n", ram_wr_n, 0);
        chk("contest_cpu_first_rd_n", ram_rd_n, 1);
        for (int k = 0; k < 10 && !cpu_ack; k++) @(negedge clk);
        chk("contest_ack", cpu_ack, 1);
        @(posedge clk); #1 cpu_req = 1'b0;

        // back-to-back CPU writes during the scan: both sides keep progressing
        c0 = cyc; p0 = n_pops;
        for (int n = 0; n < 20; n++) begin
            logic [10:0] a;
            a = 11'($urandom_range(0, 2047));
            cpu_op(1'b1, a, mem_m[a], lat, wlo, rlo);
        end
        chk("contention_cpu_share", (20 * 8 >= cyc - c0) ? 1 : 0, 1);
        chk("contention_scan_share", ((n_pops - p0) * 5 >= cyc - c0) ? 1 : 0, 1);
        wait_scan_done(6000);
        chk("contention_pop_count", n_pops, model_count());

        // randomised READY and CPU traffic during a scan
        preload();
        mon_reset();
        obj_ready = 1'b1;
        start_scan();
        ops_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 80; n++) begin
                    logic [10:0] a;
                    logic [7:0]  d, e;
                    int          lim;
                    lim = exp_addr;
                    if ($urandom_range(0, 1) == 1) begin
                        a = (lim > 0) ? 11'($urandom_range(0, lim - 1)) : 11'h0;
                        d = (lim > 0) ? 8'($urandom) : mem_m[a];
                        cpu_op(1'b1, a, d, lat, wlo, rlo);
                        chk("rnd_wr_latency", lat >= 3 ? 1 : 0, 1);
                        mem_m[a] = d;
                    end else begin
                        a = 11'($urandom_range(0, 2047));
                        e = mem_m[a];
                        cpu_op(1'b0, a, 8'h00, lat, wlo, rlo);
                        chk("rnd_rd_dout", cpu_dout, e);
                    end
                    repeat ($urandom_range(0, 5)) @(posedge clk);
                end
                ops_done = 1'b1;
            end
            begin
                for (int k = 0; k < 12000; k++) begin
                    @(posedge clk); #1;
                    obj_ready = ($urandom_range(0, 3) != 0);
                    if (ops_done && !scan_busy) break;
                end
            end
        join
        obj_ready = 1'b1;
        wait_scan_done(6000);
        chk("rnd_pop_count", n_pops, model_count());
        chk("rnd_end_addr", exp_addr, 2048);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
